// File: rtl/act_pkg.sv
// Shared constants and types for the act_custom_rtype activation accelerator:
// instruction decode fields, activation modes, STAT word layout and FP32 fields.
package act_pkg;

  localparam logic [6:0] OPC_CUSTOM = 7'h33;
  localparam logic [6:0] F7_ACT     = 7'h04;

  localparam logic [2:0] F3_AWR   = 3'b000;
  localparam logic [2:0] F3_START = 3'b001;
  localparam logic [2:0] F3_STAT  = 3'b010;
  localparam logic [2:0] F3_YRD   = 3'b011;
  localparam logic [2:0] F3_PCNT  = 3'b100;

  typedef enum logic [1:0] {
    MODE_RELU  = 2'd0,
    MODE_LEAKY = 2'd1,
    MODE_CLAMP = 2'd2,
    MODE_IDENT = 2'd3
  } act_mode_e;

  localparam int STAT_DONE_BIT   = 0;
  localparam int STAT_BUSY_BIT   = 1;
  localparam int STAT_ERR_BIT    = 2;
  localparam int STAT_CVALID_BIT = 3;
  localparam int STAT_MODE_LSB   = 4;
  localparam int STAT_RUNCYC_LSB = 16;

  localparam int         FP_SIGN_BIT = 31;
  localparam int         FP_EXP_MSB  = 30;
  localparam int         FP_EXP_LSB  = 23;
  localparam int         FP_MAN_MSB  = 22;
  localparam logic [7:0] FP_EXP_MAX  = 8'hFF;

endpackage

// File: rtl/act_lane.sv
// Combinational single-element activation: applies ReLU, leaky-ReLU (exponent
// shift), clamped ReLU or identity to one FP32 bit pattern.
module act_lane
  import act_pkg::*;
(
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  input  logic [31:0] param,
  output logic [31:0] y
);

  logic [7:0]  exp_x;
  logic [7:0]  shift;
  logic [31:0] clamp_c;

  always_comb begin
    exp_x   = x[FP_EXP_MSB:FP_EXP_LSB];
    shift   = {3'b000, param[4:0]};
    clamp_c = param[FP_SIGN_BIT] ? 32'h0 : param;
    y       = x;
    case (act_mode_e'(mode))
      MODE_RELU:  y = x[FP_SIGN_BIT] ? 32'h0 : x;
      MODE_LEAKY: begin
        // Negative infinities/NaNs pass through; values that would underflow flush to +0.
        if (x[FP_SIGN_BIT] && (exp_x != FP_EXP_MAX)) begin
          if (exp_x <= shift) y = 32'h0;
          else                y = {x[FP_SIGN_BIT], exp_x - shift, x[FP_MAN_MSB:0]};
        end
      end
      MODE_CLAMP: y = x[FP_SIGN_BIT] ? 32'h0 : ((x < clamp_c) ? x : clamp_c);
      default:    y = x;
    endcase
  end

endmodule

// File: rtl/act_custom_rtype.sv
// Element-wise activation engine behind a custom R-type port (AWR/START/STAT/YRD/PCNT).
// Define ACT_PERF_CNT_EN to add the busy-cycle accumulator read by PCNT.
module act_custom_rtype
  import act_pkg::*;
#(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int LANES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        accel_busy,
  output logic        accel_done,
  output logic        accel_C_valid
);

  localparam int ELEMS  = M * N;
  localparam int GROUPS = ELEMS / LANES;
  localparam int IDX_W  = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int CNT_W  = $clog2(GROUPS + 1);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("act_custom_rtype: only DATA_W=32 is supported");
  end
  if ((ELEMS % LANES) != 0) begin : g_bad_lanes
    $error("act_custom_rtype: M*N must be a multiple of LANES");
  end

  logic              is_act, is_awr, is_start, is_stat, is_yrd, is_pcnt;
  logic [2:0]        funct3;
  logic              accept, in_range;
  logic [ADDR_W-1:0] row, col;
  logic [IDX_W-1:0]  flat_idx;
  logic              unused_instr_bits;

  logic [DATA_W-1:0] x_mem [ELEMS];
  logic [DATA_W-1:0] y_mem [ELEMS];

  logic              busy, c_valid, done_sticky, err;
  act_mode_e         mode;
  logic [31:0]       param;
  logic [15:0]       run_cycles;
  logic [CNT_W-1:0]  cnt;
  logic [GRP_W-1:0]  rd_grp, pipe_grp;
  logic              pipe_valid;
  logic [DATA_W-1:0] lane_x [LANES];
  logic [DATA_W-1:0] lane_y [LANES];
  logic [DATA_W-1:0] pipe_y [LANES];
  logic [31:0]       stat_word, rd_data_next, pcnt_value;

  assign funct3   = instr[14:12];
  assign is_act   = (instr[6:0] == OPC_CUSTOM) && (instr[31:25] == F7_ACT);
  assign is_awr   = is_act && (funct3 == F3_AWR);
  assign is_start = is_act && (funct3 == F3_START);
  assign is_stat  = is_act && (funct3 == F3_STAT);
  assign is_yrd   = is_act && (funct3 == F3_YRD);
  assign is_pcnt  = is_act && (funct3 == F3_PCNT);
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  // STAT and foreign instructions never stall; everything touching X/Y waits out a run.
  assign instr_ready = !(busy && (is_awr || is_start || is_yrd || is_pcnt));
  assign accept      = instr_valid && instr_ready;

  assign row      = rs1_val[2*ADDR_W-1:ADDR_W];
  assign col      = rs1_val[ADDR_W-1:0];
  assign in_range = (32'(row) < 32'(M)) && (32'(col) < 32'(N));
  assign flat_idx = IDX_W'(32'(row) * 32'(N) + 32'(col));

  assign rd_grp = (32'(cnt) < 32'(GROUPS)) ? GRP_W'(cnt) : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_x[l] = x_mem[IDX_W'(32'(rd_grp) * 32'(LANES) + 32'(l))];
    act_lane u_lane (
      .x     (lane_x[l]),
      .mode  (mode),
      .param (param),
      .y     (lane_y[l])
    );
  end

  always_ff @(posedge clk) begin
    if (accept && is_awr && in_range) x_mem[flat_idx] <= rs2_val;
  end

  always_ff @(posedge clk) begin
    if (pipe_valid) begin
      for (int l = 0; l < LANES; l++) begin
        y_mem[IDX_W'(32'(pipe_grp) * 32'(LANES) + 32'(l))] <= pipe_y[l];
      end
    end
  end

`ifdef ACT_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  perf_cnt <= '0;
    else if (accept && is_pcnt && rs1_val[0])    perf_cnt <= '0;
    else if (busy)                               perf_cnt <= perf_cnt + 32'd1;
  end

  assign pcnt_value = perf_cnt;
`else
  assign pcnt_value = 32'h0;
`endif

  always_comb begin
    stat_word                                = '0;
    stat_word[STAT_DONE_BIT]                 = done_sticky;
    stat_word[STAT_BUSY_BIT]                 = busy;
    stat_word[STAT_ERR_BIT]                  = err;
    stat_word[STAT_CVALID_BIT]               = c_valid;
    stat_word[STAT_MODE_LSB +: 2]            = mode;
    stat_word[STAT_RUNCYC_LSB +: 16]         = run_cycles;
    rd_data_next = stat_word;
    if (is_yrd)       rd_data_next = in_range ? y_mem[flat_idx] : 32'h0;
    else if (is_pcnt) rd_data_next = pcnt_value;
  end

  // Engine: cycles 0..GROUPS-1 register lane results, the final cycle drains the pipe into Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      cnt         <= '0;
      pipe_valid  <= 1'b0;
      pipe_grp    <= '0;
      for (int l = 0; l < LANES; l++) pipe_y[l] <= '0;
      accel_done  <= 1'b0;
      c_valid     <= 1'b0;
      done_sticky <= 1'b0;
      err         <= 1'b0;
      mode        <= MODE_RELU;
      param       <= '0;
      run_cycles  <= '0;
      rd_we       <= 1'b0;
      rd_waddr    <= '0;
      rd_wdata    <= '0;
    end else begin
      accel_done <= 1'b0;
      rd_we      <= 1'b0;
      pipe_valid <= 1'b0;
      if (busy) begin
        run_cycles <= run_cycles + 16'd1;
        if (32'(cnt) < 32'(GROUPS)) begin
          pipe_valid <= 1'b1;
          pipe_grp   <= rd_grp;
          pipe_y     <= lane_y;
        end
        if (32'(cnt) == 32'(GROUPS)) begin
          busy        <= 1'b0;
          accel_done  <= 1'b1;
          c_valid     <= 1'b1;
          done_sticky <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (accept) begin
        if (is_awr) begin
          c_valid     <= 1'b0;
          done_sticky <= 1'b0;
          if (!in_range) err <= 1'b1;
        end
        if (is_start) begin
          mode        <= act_mode_e'(rs1_val[1:0]);
          param       <= rs2_val;
          c_valid     <= 1'b0;
          err         <= 1'b0;
          done_sticky <= 1'b0;
          busy        <= 1'b1;
          cnt         <= '0;
          run_cycles  <= '0;
        end
        if (is_yrd && !in_range) err <= 1'b1;
        if (is_stat || is_yrd || is_pcnt) begin
          rd_we    <= 1'b1;
          rd_waddr <= rd_addr;
          rd_wdata <= rd_data_next;
        end
      end
    end
  end

  assign accel_busy    = busy;
  assign accel_C_valid = c_valid;

endmodule

// File: tb/tb_act_custom_rtype.sv
// Self-checking bench for act_custom_rtype: directed activation vectors plus
// randomized X/mode/param rounds compared against a behavioural model.
`timescale 1ns/1ps
module tb_act_custom_rtype;
  import act_pkg::*;

  localparam int M          = 8;
  localparam int N          = 8;
  localparam int LANES      = 4;
  localparam int ELEMS      = M * N;
  localparam int RUN_CYCLES = ELEMS / LANES + 1;
`ifdef ACT_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        accel_busy;
  logic        accel_done;
  logic        accel_C_valid;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] xModel [ELEMS];
  logic [31:0] yModel [ELEMS];
  logic [1:0]  modelMode;
  logic [31:0] modelParam;
  logic        modelErr, modelCValid, modelDone;
  logic [15:0] modelRunCycles;
  logic [31:0] modelPerf;

  act_custom_rtype dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .rd_addr       (rd_addr),
    .rd_we         (rd_we),
    .rd_waddr      (rd_waddr),
    .rd_wdata      (rd_wdata),
    .accel_busy    (accel_busy),
    .accel_done    (accel_done),
    .accel_C_valid (accel_C_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Reference activation written straight from the per-mode rules.
  function automatic logic [31:0] refAct(input logic [31:0] x, input logic [1:0] m, input logic [31:0] p);
    int          expo  = int'(x[30:23]);
    int          shamt = int'(p[4:0]);
    logic        neg   = x[31];
    logic [31:0] limit = p[31] ? 32'h0 : p;
    case (m)
      2'd0: return neg ? 32'h0 : x;
      2'd1: begin
        if (!neg || expo == 255) return x;
        if (expo <= shamt) return 32'h0;
        return {1'b1, 8'(expo - shamt), x[22:0]};
      end
      2'd2: begin
        if (neg) return 32'h0;
        return (x < limit) ? x : limit;
      end
      default: return x;
    endcase
  endfunction

  function automatic logic [31:0] expStat(input logic busyBit);
    return {modelRunCycles, 10'd0, modelMode, modelCValid, modelErr, busyBit, modelDone};
  endfunction

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 4))
      0: return $urandom();
      1: return 32'h80000000;
      2: return 32'hFF800000;
      3: return {1'($urandom()), 8'($urandom_range(0, 4)), 23'($urandom())};
      default: return {1'($urandom()), 8'($urandom_range(100, 150)), 23'($urandom())};
    endcase
  endfunction

  task automatic applyStimulus(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    int waitCycles = 0;
    @(negedge clk);
    instr       = {f7, 10'($urandom()), f3, 5'($urandom()), OPC_CUSTOM};
    rs1_val     = a;
    rs2_val     = b;
    rd_addr     = rd;
    instr_valid = 1'b1;
    #1;
    while (!instr_ready && waitCycles < 200) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("accept_in_time", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] f3, input logic [31:0] a, input string tag, input logic [31:0] expected);
    logic [4:0] rd;
    rd = 5'($urandom_range(1, 31));
    applyStimulus(F7_ACT, f3, a, 32'h0, rd);
    @(negedge clk);
    checkOutput({tag, "_we"}, 32'(rd_we), 32'd1);
    checkOutput({tag, "_waddr"}, 32'(rd_waddr), 32'(rd));
    checkOutput(tag, rd_wdata, expected);
  endtask

  task automatic writeX(input int r, input int c, input logic [31:0] v);
    applyStimulus(F7_ACT, F3_AWR, {16'(r), 16'(c)}, v, 5'd0);
    modelCValid = 1'b0;
    modelDone   = 1'b0;
    if (r < M && c < N) xModel[r*N + c] = v;
    else                modelErr = 1'b1;
  endtask

  task automatic readY(input int r, input int c);
    readReg(F3_YRD, {16'(r), 16'(c)}, "yrd", yModel[r*N + c]);
  endtask

  task automatic startRun(input logic [1:0] m, input logic [31:0] p);
    applyStimulus(F7_ACT, F3_START, {30'($urandom()), m}, p, 5'd0);
    modelMode   = m;
    modelParam  = p;
    modelErr    = 1'b0;
    modelCValid = 1'b0;
    modelDone   = 1'b0;
  endtask

  task automatic finishRun(input int expBusy);
    int busyCount = 0;
    bit sawDone   = 1'b0;
    for (int c = 0; c < 100 && !sawDone; c++) begin
      @(negedge clk);
      if (accel_done)      sawDone = 1'b1;
      else if (accel_busy) busyCount++;
    end
    checkOutput("run_done_seen", 32'(sawDone), 32'd1);
    checkOutput("run_busy_cycles", 32'(busyCount), 32'(expBusy));
    checkOutput("done_busy_low", 32'(accel_busy), 32'd0);
    checkOutput("done_cvalid", 32'(accel_C_valid), 32'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(accel_done), 32'd0);
    for (int i = 0; i < ELEMS; i++) yModel[i] = refAct(xModel[i], modelMode, modelParam);
    modelRunCycles = 16'(RUN_CYCLES);
    modelCValid    = 1'b1;
    modelDone      = 1'b1;
    modelPerf      = modelPerf + 32'(RUN_CYCLES);
  endtask

  task automatic runEngine(input logic [1:0] m, input logic [31:0] p);
    startRun(m, p);
    finishRun(RUN_CYCLES);
  endtask

  task automatic resetModel();
    modelMode      = 2'd0;
    modelParam     = 32'h0;
    modelErr       = 1'b0;
    modelCValid    = 1'b0;
    modelDone      = 1'b0;
    modelRunCycles = 16'd0;
    modelPerf      = 32'h0;
  endtask

  initial begin
    logic [31:0] pattern [8];
    logic [1:0]  m;
    logic [31:0] p;
    int          idx;

    pattern = '{32'hBF800000, 32'h3F800000, 32'h80000000, 32'h00000000,
                32'hC1200000, 32'h40000000, 32'hC0000000, 32'h40400000};
    instr_valid = 1'b0;
    instr       = 32'h0;
    rs1_val     = 32'h0;
    rs2_val     = 32'h0;
    rd_addr     = 5'd0;
    rst_n       = 1'b0;
    resetModel();

    #12;
    checkOutput("rst_instr_ready", 32'(instr_ready), 32'd1);
    checkOutput("rst_rd_we", 32'(rd_we), 32'd0);
    checkOutput("rst_rd_waddr", 32'(rd_waddr), 32'd0);
    checkOutput("rst_rd_wdata", rd_wdata, 32'h0);
    checkOutput("rst_busy", 32'(accel_busy), 32'd0);
    checkOutput("rst_done", 32'(accel_done), 32'd0);
    checkOutput("rst_cvalid", 32'(accel_C_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    readReg(F3_STAT, 32'h0, "stat_after_reset", 32'h0);

    applyStimulus(7'h05, F3_STAT, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    checkOutput("foreign_no_we", 32'(rd_we), 32'd0);

    $display("[TB] ReLU pattern");
    for (int i = 0; i < ELEMS; i++) writeX(i / N, i % N, pattern[i % 8]);
    runEngine(2'd0, 32'h0);
    for (int c = 0; c < 8; c++) readY(3, c);
    readReg(F3_STAT, 32'h0, "stat_relu", 32'h00110009);

    $display("[TB] Leaky and clamp vectors");
    writeX(0, 0, 32'hC1200000);
    writeX(0, 1, 32'h80000001);
    writeX(0, 2, 32'hFF800000);
    writeX(0, 3, 32'h3F800000);
    runEngine(2'd1, 32'd2);
    readReg(F3_YRD, {16'd0, 16'd0}, "leaky_neg", 32'hC0200000);
    readReg(F3_YRD, {16'd0, 16'd1}, "leaky_denorm", 32'h00000000);
    readReg(F3_YRD, {16'd0, 16'd2}, "leaky_neginf", 32'hFF800000);
    readReg(F3_YRD, {16'd0, 16'd3}, "leaky_pos", 32'h3F800000);
    writeX(0, 0, 32'h41000000);
    writeX(0, 1, 32'h40400000);
    writeX(0, 2, 32'hBF800000);
    runEngine(2'd2, 32'h40C00000);
    readReg(F3_YRD, {16'd0, 16'd0}, "clamp_hi", 32'h40C00000);
    readReg(F3_YRD, {16'd0, 16'd1}, "clamp_mid", 32'h40400000);
    readReg(F3_YRD, {16'd0, 16'd2}, "clamp_neg", 32'h00000000);
    runEngine(2'd2, 32'hBF800000);
    for (int k = 0; k < 4; k++) readReg(F3_YRD, {16'(k * 2 + 1), 16'(7 - k)}, "clamp_negparam", 32'h0);

    $display("[TB] Randomized rounds");
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 12; k++) begin
        idx = $urandom_range(0, ELEMS - 1);
        writeX(idx / N, idx % N, randVal());
      end
      m = 2'($urandom_range(0, 3));
      p = (m == 2'd2 && $urandom_range(0, 1) == 0) ? {1'b0, 8'($urandom_range(120, 135)), 23'($urandom())}
                                                   : $urandom();
      runEngine(m, p);
      for (int k = 0; k < 6; k++) begin
        idx = $urandom_range(0, ELEMS - 1);
        readY(idx / N, idx % N);
      end
      readReg(F3_STAT, 32'h0, "stat_random", expStat(1'b0));
    end

    $display("[TB] Handshake while busy");
    startRun(2'd3, 32'h0);
    @(negedge clk);
    instr_valid = 1'b1;
    rs1_val     = 32'h0;
    instr = {F7_ACT, 10'd0, F3_YRD, 5'd0, OPC_CUSTOM};
    #1 checkOutput("busy_ready_yrd", 32'(instr_ready), 32'd0);
    instr = {F7_ACT, 10'd0, F3_AWR, 5'd0, OPC_CUSTOM};
    #1 checkOutput("busy_ready_awr", 32'(instr_ready), 32'd0);
    instr = {F7_ACT, 10'd0, F3_START, 5'd0, OPC_CUSTOM};
    #1 checkOutput("busy_ready_start", 32'(instr_ready), 32'd0);
    instr = {F7_ACT, 10'd0, F3_STAT, 5'd0, OPC_CUSTOM};
    rd_addr = 5'd7;
    #1 checkOutput("busy_ready_stat", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("busy_stat_we", 32'(rd_we), 32'd1);
    checkOutput("busy_stat_waddr", 32'(rd_waddr), 32'd7);
    checkOutput("busy_stat_busybit", 32'(rd_wdata[1]), 32'd1);
    checkOutput("busy_stat_cvalid", 32'(rd_wdata[3]), 32'd0);
    finishRun(RUN_CYCLES - 2);
    readY(0, 0);

    $display("[TB] Out-of-range accesses");
    writeX(8, 0, 32'h12345678);
    readReg(F3_STAT, 32'h0, "stat_awr_oor", expStat(1'b0));
    readReg(F3_YRD, {16'd0, 16'd9}, "yrd_oor", 32'h0);
    readReg(F3_STAT, 32'h0, "stat_yrd_oor", expStat(1'b0));
    runEngine(2'd3, 32'h0);
    readReg(F3_YRD, 32'h0, "x_unchanged", xModel[0]);
    readReg(F3_STAT, 32'h0, "stat_err_cleared", expStat(1'b0));

    $display("[TB] Reset mid-run");
    startRun(2'd0, 32'h0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(accel_busy), 32'd0);
    checkOutput("midrst_cvalid", 32'(accel_C_valid), 32'd0);
    checkOutput("midrst_done", 32'(accel_done), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_no_done", 32'(accel_done), 32'd0);
    rst_n = 1'b1;
    resetModel();
    readReg(F3_STAT, 32'h0, "stat_after_midrst", 32'h0);

    $display("[TB] Performance counter");
    runEngine(2'd0, 32'h0);
    runEngine(2'd3, 32'h0);
    readReg(F3_PCNT, 32'h0, "pcnt_two_runs", PERF_EN ? modelPerf : 32'h0);
    readReg(F3_PCNT, 32'h1, "pcnt_clear", PERF_EN ? modelPerf : 32'h0);
    modelPerf = 32'h0;
    readReg(F3_PCNT, 32'h0, "pcnt_after_clear", 32'h0);
    for (int k = 0; k < 4; k++) begin
      idx = $urandom_range(0, ELEMS - 1);
      readY(idx / N, idx % N);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
